adc_sample_arbiter: RTL and testbench
=====================================

ADC_SAMPLE_ARBITER -- requirements
Module: adc_sample_arbiter

Interface
REQ-001 Parameter DATA_W, default 12, sample width in bits.
REQ-002 Parameter N_CH, default 13, number of channels in the sample bank (1 internal + 3x4 external).
REQ-003 clk  input  1  system clock (65 MHz domain); all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester sample-ready flags: bit0 internal ADC, bits1..3 external ADC JA/JB/JC.
REQ-006 ch_sel  input  8  2-bit channel index per requester, requester k at [2k+1:2k]; requester 0 field ignored.
REQ-007 data_in  input  4*DATA_W  sample per requester, requester k at [DATA_W*(k+1)-1:DATA_W*k].
REQ-008 gnt  output  4  one-hot grant, one-cycle pulse.
REQ-009 sample_bus  output  N_CH*DATA_W  latest sample per channel, channel c at [DATA_W*(c+1)-1:DATA_W*c].
REQ-010 valid  output  N_CH  per-channel "updated since last frame" flags.
REQ-011 frame_done  output  1  one-cycle pulse when every channel has been updated.

Function
REQ-012 Channel map SHALL be: requester 0 -> channel 0; requester k (1..3) -> channel 1 + 4*(k-1) + ch_sel[k].
REQ-013 FSM SHALL have two states: IDLE, GRANT; reset state IDLE.
REQ-014 IDLE, no req bit set: stay IDLE, no outputs change.
REQ-015 IDLE, any req bit set: select winner w by round-robin starting at pointer ptr (search ptr, ptr+1, ... mod 4); latch data_in[w] and mapped channel into internal registers; go to GRANT.
REQ-016 GRANT: gnt[w]=1 for exactly this cycle; latched sample written to sample_bus channel slot and valid[ch] set at the end of this cycle (visible next cycle); ptr <= (w+1) mod 4; go to IDLE.
REQ-017 Latency: req seen in cycle N -> gnt in N+1 -> sample_bus/valid updated in N+2; maximum throughput one grant per 2 cycles.
REQ-018 Requester handshake: req and its data/ch_sel held stable until gnt seen; requester deasserts req the cycle after gnt; data change after the IDLE decision cycle SHALL NOT affect the stored value.
REQ-019 req deasserted by a requester before being granted: request is withdrawn, no write for it.
REQ-020 Writing a channel whose valid is already 1 overwrites the sample; valid stays 1; no error flag.
REQ-021 When a write makes all N_CH valid bits 1: frame_done=1 in the cycle the write becomes visible (N+2), and valid cleared to all zeros on the following edge; sample_bus retained.
REQ-022 frame_done SHALL be 0 in all other cycles; never asserted twice for one frame.
REQ-023 ptr wrap: after grant to requester 3, ptr = 0.
REQ-024 All four req asserted continuously: grants SHALL rotate 0,1,2,3,0,... each requester receiving one grant per 8 cycles; no starvation.
REQ-025 gnt SHALL be one-hot or zero in every cycle.

Reset
REQ-026 On rst=1 at a clock edge: state IDLE, ptr=0, gnt=0, valid=0, frame_done=0, sample_bus=0, internal latches=0.
REQ-027 rst asserted while in GRANT: pending write discarded, gnt forced 0 from the next cycle, no valid bit set.
REQ-028 rst has priority over every other event in the same cycle.

Verification
REQ-029 Single request: req=4'b0010, ch_sel[3:2]=2, data=12'hABC -> gnt=4'b0010 one cycle after, channel 3 slot = 12'hABC and valid[3]=1 two cycles after req.
REQ-030 Contention: req=4'b1111 held from reset -> gnt sequence 0001,0010,0100,1000,0001 on every second cycle.
REQ-031 Round-robin pointer: grant to requester 2, then req=4'b0101 simultaneously -> gnt=4'b0001 first (ptr=3 searches 3,0), then 4'b0100.
REQ-032 Full frame: write channels 0..12 once each with value = channel index -> frame_done single pulse with channel 12 write, valid=0 next cycle, sample_bus[155:144]=12'h00C retained.
REQ-033 Reset mid-grant: rst=1 in the GRANT cycle of a write to channel 5 -> valid[5]=0, sample_bus channel 5 = 0, ptr=0.
REQ-034 Withdrawn request: req[1] pulses one cycle while req[2] granted -> no grant or write for requester 1.

Source files
------------

// File: rtl/adc_sample_arbiter.sv
// Round-robin arbiter that collects samples from one internal and three external ADCs
// into a per-channel sample bank, flagging fresh channels and signalling complete frames.
module adc_sample_arbiter #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned N_CH   = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               req,
  input  logic [7:0]               ch_sel,
  input  logic [4*DATA_W-1:0]      data_in,
  output logic [3:0]               gnt,
  output logic [N_CH*DATA_W-1:0]   sample_bus,
  output logic [N_CH-1:0]          valid,
  output logic                     frame_done
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               ptr_q, ptr_d;
  logic [1:0]               win_q, win_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [3:0]               gnt_q, gnt_d;
  logic [N_CH*DATA_W-1:0]   bus_q, bus_d;
  logic [N_CH-1:0]          valid_q, valid_d;
  logic                     frame_done_q, frame_done_d;

  logic                     win_found;
  logic [1:0]               win_idx;
  logic [1:0]               sel_field;
  logic [CH_W-1:0]          win_ch;

  // Round-robin search starting at ptr, plus channel mapping for the winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[ptr_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(i);
      end
    end
    sel_field = ch_sel[2*win_idx +: 2];
    win_ch    = (win_idx == 2'd0) ? '0
              : CH_W'(1 + 4*(int'(win_idx) - 1) + int'(sel_field));
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    ch_d         = ch_q;
    data_d       = data_q;
    gnt_d        = '0;
    bus_d        = bus_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;

    // A completed frame is announced for one cycle, then its valid flags are retired
    if (frame_done_q) valid_d = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          win_d          = win_idx;
          ch_d           = win_ch;
          data_d         = data_in[int'(win_idx)*DATA_W +: DATA_W];
          gnt_d[win_idx] = 1'b1;
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (int'(ch_q) < int'(N_CH)) begin
          bus_d[int'(ch_q)*DATA_W +: DATA_W] = data_q;
          valid_d[ch_q]                      = 1'b1;
        end
        frame_done_d = &valid_d;
        ptr_d        = win_q + 2'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      ch_q         <= '0;
      data_q       <= '0;
      gnt_q        <= '0;
      bus_q        <= '0;
      valid_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      ch_q         <= ch_d;
      data_q       <= data_d;
      gnt_q        <= gnt_d;
      bus_q        <= bus_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gnt        = gnt_q;
  assign sample_bus = bus_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_adc_sample_arbiter.sv
// Directed bench for adc_sample_arbiter with a per-cycle behavioural reference model.
module tb_adc_sample_arbiter;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned N_CH   = 13;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             req;
  logic [7:0]             ch_sel;
  logic [4*DATA_W-1:0]    data_in;
  logic [3:0]             gnt;
  logic [N_CH*DATA_W-1:0] sample_bus;
  logic [N_CH-1:0]        valid;
  logic                   frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  adc_sample_arbiter #(.DATA_W(DATA_W), .N_CH(N_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .ch_sel     (ch_sel),
    .data_in    (data_in),
    .gnt        (gnt),
    .sample_bus (sample_bus),
    .valid      (valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a pending transfer, a rotating start point and the channel bank
  bit          m_ready = 0;
  bit          m_pend;
  int          m_ptr, m_w, m_ch;
  logic [11:0] m_data;
  logic [3:0]  m_gnt;
  bit          m_fd, m_fd_next;
  logic [11:0] m_bus   [N_CH];
  bit          m_valid [N_CH];
  int          m_cnt;

  function automatic int ch_of(input int k, input logic [7:0] sel);
    if (k == 0) return 0;
    return 1 + 4*(k-1) + int'(sel[2*k +: 2]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1; m_pend = 0; m_ptr = 0; m_w = 0; m_ch = 0; m_data = '0;
      m_gnt = '0; m_fd = 0;
      for (int c = 0; c < N_CH; c++) begin m_bus[c] = '0; m_valid[c] = 0; end
    end else if (m_ready) begin
      m_fd_next = 0;
      m_gnt     = '0;
      if (m_fd) for (int c = 0; c < N_CH; c++) m_valid[c] = 0;
      if (m_pend) begin
        m_bus[m_ch]   = m_data;
        m_valid[m_ch] = 1;
        m_cnt = 0;
        for (int c = 0; c < N_CH; c++) m_cnt += int'(m_valid[c]);
        m_fd_next = (m_cnt == N_CH);
        m_ptr  = (m_w + 1) % 4;
        m_pend = 0;
      end else if (req != 4'b0) begin
        for (int i = 3; i >= 0; i--)
          if (req[(m_ptr + i) % 4]) m_w = (m_ptr + i) % 4;
        m_gnt[m_w] = 1'b1;
        m_ch   = ch_of(m_w, ch_sel);
        m_data = data_in[m_w*DATA_W +: DATA_W];
        m_pend = 1;
      end
      m_fd = m_fd_next;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  logic [N_CH*DATA_W-1:0] e_bus;
  logic [N_CH-1:0]        e_valid;
  always @(negedge clk) begin
    if (m_ready) begin
      for (int c = 0; c < N_CH; c++) begin
        e_bus[c*DATA_W +: DATA_W] = m_bus[c];
        e_valid[c]                = m_valid[c];
      end
      chk("model_gnt",        160'(gnt),        160'(m_gnt));
      chk("model_frame_done", 160'(frame_done), 160'(m_fd));
      chk("model_valid",      160'(valid),      160'(e_valid));
      chk("model_sample_bus", 160'(sample_bus), 160'(e_bus));
      chk("gnt_onehot0",      160'($onehot0(gnt)), 160'(1));
    end
  end

  task automatic do_write(input int k, input int sel, input logic [11:0] val);
    bit got;
    req = '0;
    req[k] = 1'b1;
    ch_sel[2*k +: 2] = 2'(sel);
    data_in[k*DATA_W +: DATA_W] = val;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (gnt[k]) got = 1;
    end
    chk("write_grant_seen", 160'(got), 160'(1));
    req = '0;
  endtask

  logic [3:0] exp_seq [9];
  bit         got2;

  initial begin
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    rst = 1'b1; req = '0; ch_sel = '0; data_in = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_gnt",   160'(gnt),        160'(0));
    chk("reset_valid", 160'(valid),      160'(0));
    chk("reset_fd",    160'(frame_done), 160'(0));
    chk("reset_bus",   160'(sample_bus), 160'(0));

    // Single request: requester 1, channel select 2 -> channel 3
    req = 4'b0010; ch_sel = 8'b0000_1000; data_in[23:12] = 12'hABC;
    step();
    chk("single_gnt", 160'(gnt), 160'(4'b0010));
    req = '0; data_in[23:12] = 12'hFFF;
    step();
    chk("single_ch3",   160'(sample_bus[47:36]), 160'(12'hABC));
    chk("single_valid", 160'(valid),             160'(13'h0008));
    chk("single_gnt_off", 160'(gnt), 160'(0));

    // Grant requester 2 (channel 6) while requester 1 pulses briefly
    req = 4'b0100; ch_sel[5:4] = 2'd1; data_in[35:24] = 12'h222;
    step();
    chk("rr_gnt2", 160'(gnt), 160'(4'b0100));
    req = 4'b0010;
    step();
    chk("withdraw_no_gnt", 160'(gnt), 160'(0));
    chk("rr_ch6", 160'(sample_bus[83:72]), 160'(12'h222));
    req = 4'b0101; data_in[11:0] = 12'h111; data_in[35:24] = 12'h333;
    step();
    chk("rr_wrap_gnt0", 160'(gnt), 160'(4'b0001));
    req = 4'b0100;
    step();
    chk("rr_ch0", 160'(sample_bus[11:0]), 160'(12'h111));
    step();
    chk("rr_then_gnt2", 160'(gnt), 160'(4'b0100));
    req = '0;
    step();
    chk("overwrite_ch6", 160'(sample_bus[83:72]), 160'(12'h333));
    chk("withdraw_ch2_untouched", 160'(sample_bus[35:24]), 160'(0));
    chk("overwrite_valid", 160'(valid), 160'(13'h0049));

    // Full frame: channels 0..12 written with their own index
    do_write(0, 0, 12'h000);
    for (int k = 1; k < 4; k++)
      for (int s = 0; s < 4; s++)
        do_write(k, s, 12'(1 + 4*(k-1) + s));
    step();
    chk("frame_done_pulse", 160'(frame_done), 160'(1));
    chk("frame_valid_full", 160'(valid),      160'(13'h1FFF));
    chk("frame_ch12",       160'(sample_bus[155:144]), 160'(12'h00C));
    step();
    chk("frame_done_clear", 160'(frame_done), 160'(0));
    chk("frame_valid_zero", 160'(valid),      160'(0));
    chk("frame_ch12_kept",  160'(sample_bus[155:144]), 160'(12'h00C));
    chk("frame_ch7_kept",   160'(sample_bus[95:84]),   160'(12'h007));

    // Contention: all four requesting from reset
    rst = 1'b1; req = 4'b1111;
    step();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("contention_gnt", 160'(gnt), 160'(exp_seq[i]));
    end
    req = '0;
    step(); step();

    // Reset during the grant cycle of a channel-5 write
    req = 4'b0100; ch_sel[5:4] = 2'd0; data_in[35:24] = 12'h555;
    got2 = 0;
    for (int i = 0; i < 8 && !got2; i++) begin
      step();
      if (gnt[2]) got2 = 1;
    end
    chk("rst_mid_grant_seen", 160'(got2), 160'(1));
    rst = 1'b1; req = '0;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", 160'(valid),             160'(0));
    chk("rst_mid_ch5",   160'(sample_bus[71:60]), 160'(0));
    chk("rst_mid_gnt",   160'(gnt),               160'(0));
    req = 4'b1010;
    step();
    chk("rst_ptr_zero", 160'(gnt), 160'(4'b0010));
    req = '0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
